// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// vga_pkg : shared VGA timing defaults, colour constants and sync helper.
// Rev 1.0
// ============================================================================
package vga_pkg;

    localparam int H_VISIBLE = 640;
    localparam int H_FRONT   = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BACK    = 48;
    localparam int H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;

    localparam int V_VISIBLE = 480;
    localparam int V_FRONT   = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BACK    = 33;
    localparam int V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    typedef logic [11:0] rgb_t;

    localparam rgb_t BLACK = 12'h000;
    localparam rgb_t WHITE = 12'hFFF;
    localparam rgb_t RED   = 12'hF00;
    localparam rgb_t GREEN = 12'h0F0;

    // Pin level for a sync pulse given whether it is active and its polarity.
    function automatic logic sync_level(input logic active, input logic pol);
        return active ? pol : ~pol;
    endfunction

endpackage
`default_nettype wire

// File: rtl/clk_en_div.sv
`default_nettype none
// ============================================================================
// clk_en_div : one-Clk strobe every CLK_DIV enabled cycles.
// Rev 1.0
// ============================================================================
module clk_en_div #(
    parameter int CLK_DIV = 4
) (
    input  logic Clk,
    input  logic Reset,
    input  logic En,
    output logic pix_en
);

    localparam int W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [W-1:0] DIV_LAST = W'(CLK_DIV - 1);

    logic [W-1:0] div_q;
    logic [W-1:0] div_d;

    always_comb begin
        div_d = div_q;
        if (En) begin
            div_d = (div_q == DIV_LAST) ? '0 : div_q + W'(1);
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

    assign pix_en = En && (div_q == DIV_LAST);

endmodule
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// vga_timing_gen : VGA raster counters, visible/sync decodes and frame strobes.
// Rev 1.0
// ============================================================================
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int   CLK_DIV   = 4,
    parameter int   H_VISIBLE = vga_pkg::H_VISIBLE,
    parameter int   H_FRONT   = vga_pkg::H_FRONT,
    parameter int   H_SYNC    = vga_pkg::H_SYNC,
    parameter int   H_BACK    = vga_pkg::H_BACK,
    parameter int   V_VISIBLE = vga_pkg::V_VISIBLE,
    parameter int   V_FRONT   = vga_pkg::V_FRONT,
    parameter int   V_SYNC    = vga_pkg::V_SYNC,
    parameter int   V_BACK    = vga_pkg::V_BACK,
    parameter logic SYNC_POL  = 1'b0
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        En,
    output logic [9:0]  hCount,
    output logic [9:0]  vCount,
    output logic        bright,
    output logic        hSync,
    output logic        vSync,
    output logic        pix_en,
    output logic        line_end,
    output logic        frame_start,
    output logic [15:0] frame_count
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] HS_FIRST = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_LAST  = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_LAST  = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

    logic        w_pix_en;
    logic        w_line_end;
    logic        w_frame_start;

    logic [9:0]  hcount_q, hcount_d;
    logic [9:0]  vcount_q, vcount_d;
    logic [15:0] frame_count_q, frame_count_d;
    logic        hsync_q, hsync_d;
    logic        vsync_q, vsync_d;

    clk_en_div #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_en_div (
        .Clk     (Clk),
        .Reset   (Reset),
        .En      (En),
        .pix_en  (w_pix_en)
    );

    // Counters reset to the last position so the first pixel advance is a
    // genuine frame wrap to (0,0).
    always_comb begin
        w_line_end    = w_pix_en && (hcount_q == H_LAST);
        w_frame_start = w_line_end && (vcount_q == V_LAST);

        hcount_d = hcount_q;
        vcount_d = vcount_q;
        if (w_pix_en) begin
            if (w_line_end) begin
                hcount_d = '0;
                vcount_d = (vcount_q == V_LAST) ? '0 : vcount_q + 10'd1;
            end else begin
                hcount_d = hcount_q + 10'd1;
            end
        end

        frame_count_d = frame_count_q + 16'(w_frame_start);

        hsync_d = sync_level((hcount_q >= HS_FIRST) && (hcount_q <= HS_LAST), SYNC_POL);
        vsync_d = sync_level((vcount_q >= VS_FIRST) && (vcount_q <= VS_LAST), SYNC_POL);
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            hcount_q      <= H_LAST;
            vcount_q      <= V_LAST;
            frame_count_q <= '0;
            hsync_q       <= ~SYNC_POL;
            vsync_q       <= ~SYNC_POL;
        end else begin
            hcount_q      <= hcount_d;
            vcount_q      <= vcount_d;
            frame_count_q <= frame_count_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
        end
    end

    assign hCount      = hcount_q;
    assign vCount      = vcount_q;
    assign bright      = (hcount_q < H_VIS) && (vcount_q < V_VIS);
    assign hSync       = hsync_q;
    assign vSync       = vsync_q;
    assign pix_en      = w_pix_en;
    assign line_end    = w_line_end;
    assign frame_start = w_frame_start;
    assign frame_count = frame_count_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_vga_timing_gen : directed scoreboard bench, full-size and shrunken raster.
// Rev 1.0
// ============================================================================
module tb_vga_timing_gen;

    logic Clk = 1'b0;
    logic Reset, En, Reset_s, En_s;

    logic [9:0]  hCount, vCount, s_hCount, s_vCount;
    logic        bright, hSync, vSync, pix_en, line_end, frame_start;
    logic        s_bright, s_hSync, s_vSync, s_pix_en, s_line_end, s_frame_start;
    logic [15:0] frame_count, s_frame_count;

    always #5 Clk = ~Clk;

    vga_timing_gen dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .En          (En),
        .hCount      (hCount),
        .vCount      (vCount),
        .bright      (bright),
        .hSync       (hSync),
        .vSync       (vSync),
        .pix_en      (pix_en),
        .line_end    (line_end),
        .frame_start (frame_start),
        .frame_count (frame_count)
    );

    // Shrunken raster (14x10 pixels, 2 Clk per pixel, active-high syncs)
    // so whole frames fit in a short run.
    vga_timing_gen #(
        .CLK_DIV   (2),
        .H_VISIBLE (8), .H_FRONT (2), .H_SYNC (3), .H_BACK (1),
        .V_VISIBLE (5), .V_FRONT (1), .V_SYNC (2), .V_BACK (2),
        .SYNC_POL  (1'b1)
    ) dut_s (
        .Clk         (Clk),
        .Reset       (Reset_s),
        .En          (En_s),
        .hCount      (s_hCount),
        .vCount      (s_vCount),
        .bright      (s_bright),
        .hSync       (s_hSync),
        .vSync       (s_vSync),
        .pix_en      (s_pix_en),
        .line_end    (s_line_end),
        .frame_start (s_frame_start),
        .frame_count (s_frame_count)
    );

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } sb_t;

    sb_t sb_q[$];
    int  n_vec = 0;
    int  n_err = 0;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic push(input string tag, input logic [31:0] exp);
        sb_t e;
        e.tag = tag;
        e.exp = exp;
        sb_q.push_back(e);
    endtask

    task automatic check(input logic [31:0] obs);
        sb_t e;
        n_vec++;
        if (sb_q.size() == 0) begin
            n_err++;
            $error("FAIL sb_empty observed=%0h expected=<entry>", obs);
        end else begin
            e = sb_q.pop_front();
            assert (obs === e.exp) else begin
                n_err++;
                $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.exp);
            end
        end
    endtask

    initial begin
        int  bad, nb, nhs, nle, npe, nstr, nfs, nvis, nvs, spbad, last;
        int  hp, vp, he, ve, pp;
        logic hs_exp, vs_exp, br_exp;

        Reset = 1'b1; En = 1'b0; Reset_s = 1'b1; En_s = 1'b0;
        repeat (3) tick();

        // Reset values
        push("rst_h", 32'd799);     check(32'(hCount));
        push("rst_v", 32'd524);     check(32'(vCount));
        push("rst_bright", 32'd0);  check(32'(bright));
        push("rst_hsync", 32'd1);   check(32'(hSync));
        push("rst_vsync", 32'd1);   check(32'(vSync));
        push("rst_fcount", 32'd0);  check(32'(frame_count));
        push("rst_strobes", 32'd0); check(32'({pix_en, line_end, frame_start}));

        // First frame: frame_start on the 3rd sample, registered on the 4th edge
        Reset = 1'b0; En = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            push($sformatf("first_fs_clk%0d", k), 32'(k == 3));
            tick();
            check(32'(frame_start));
        end
        push("first_h", 32'd0);      check(32'(hCount));
        push("first_v", 32'd0);      check(32'(vCount));
        push("first_bright", 32'd1); check(32'(bright));
        push("first_fcount", 32'd1); check(32'(frame_count));

        // One full line, sample j holds pixel j/4
        bad = 0; nb = 0; nhs = 0; nle = 0; npe = 0;
        for (int j = 0; j < 3200; j++) begin
            hp = (j == 0) ? 799 : (j - 1) / 4;
            hs_exp = !((hp >= 656) && (hp <= 751));
            if ((hCount !== 10'(j / 4)) || (vCount !== 10'd0) || (hSync !== hs_exp)) bad++;
            if (bright)   nb++;
            if (!hSync)   nhs++;
            if (line_end) nle++;
            if (pix_en)   npe++;
            tick();
        end
        push("line_trace_bad", 32'd0);   check(32'(bad));
        push("line_bright_clk", 32'd2560); check(32'(nb));
        push("line_hsync_low", 32'd384); check(32'(nhs));
        push("line_end_count", 32'd1);   check(32'(nle));
        push("line_pix_en", 32'd800);    check(32'(npe));
        push("line2_v", 32'd1);          check(32'(vCount));
        push("line2_h", 32'd0);          check(32'(hCount));

        // Freeze at hCount=639 on the strobe cycle
        repeat (639 * 4 + 3) tick();
        push("frz_pre_pix_en", 32'd1); check(32'(pix_en));
        En = 1'b0;
        bad = 0; nstr = 0;
        for (int k = 0; k < 37; k++) begin
            tick();
            if ((hCount !== 10'd639) || (vCount !== 10'd1) ||
                (frame_count !== 16'd1) || (bright !== 1'b1)) bad++;
            if (pix_en || line_end || frame_start) nstr++;
        end
        push("frz_hold_bad", 32'd0); check(32'(bad));
        push("frz_strobes", 32'd0);  check(32'(nstr));
        En = 1'b1;
        tick();
        push("resume_h", 32'd640);    check(32'(hCount));
        push("resume_bright", 32'd0); check(32'(bright));

        // Asynchronous reset mid-line inside the hsync pulse
        repeat (60 * 4) tick();
        push("pre_rst_hsync", 32'd0); check(32'(hSync));
        Reset = 1'b1;
        #1;
        push("midrst_h", 32'd799);    check(32'(hCount));
        push("midrst_v", 32'd524);    check(32'(vCount));
        push("midrst_hsync", 32'd1);  check(32'(hSync));
        push("midrst_fcount", 32'd0); check(32'(frame_count));
        tick();
        Reset = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            push($sformatf("rerel_fs_clk%0d", k), 32'(k == 3));
            tick();
            check(32'(frame_start));
        end
        push("rerel_fcount", 32'd1); check(32'(frame_count));

        // Shrunken raster: full frames of vertical timing
        Reset_s = 1'b0; En_s = 1'b1;
        tick();
        push("s_first_fs", 32'd1); check(32'(s_frame_start));
        bad = 0; nfs = 0; nvis = 0; nvs = 0; spbad = 0; last = 1;
        for (int k = 2; k < 842; k++) begin
            tick();
            pp = (k - 2) / 2;
            he = pp % 14;
            ve = (pp / 14) % 10;
            if (k == 2) begin
                hp = 13; vp = 9;
            end else begin
                pp = (k - 3) / 2;
                hp = pp % 14;
                vp = (pp / 14) % 10;
            end
            br_exp = (he < 8) && (ve < 5);
            hs_exp = (hp >= 10) && (hp <= 12);
            vs_exp = (vp >= 6) && (vp <= 7);
            if ((s_hCount !== 10'(he)) || (s_vCount !== 10'(ve)) || (s_bright !== br_exp) ||
                (s_hSync !== hs_exp) || (s_vSync !== vs_exp)) bad++;
            if (s_bright && (s_vCount >= 10'd5)) nvis++;
            if (s_vSync) nvs++;
            if (s_frame_start) begin
                if (k - last != 280) spbad++;
                last = k;
                nfs++;
            end
        end
        push("s_trace_bad", 32'd0);     check(32'(bad));
        push("s_bright_blank", 32'd0);  check(32'(nvis));
        push("s_vsync_clk", 32'd168);   check(32'(nvs));
        push("s_fs_count", 32'd3);      check(32'(nfs));
        push("s_fs_spacing", 32'd0);    check(32'(spbad));
        push("s_fcount", 32'd3);        check(32'(s_frame_count));

        // frame_count wrap: preload 0xFFFF on a frame_start cycle
        push("wrap_fs_live", 32'd1);    check(32'(s_frame_start));
        force dut_s.frame_count_q = 16'hFFFF;
        #1;
        release dut_s.frame_count_q;
        #1;
        push("wrap_preload", 32'hFFFF); check(32'(s_frame_count));
        tick();
        push("wrap_zero", 32'd0);       check(32'(s_frame_count));

        // Asynchronous reset mid-frame inside the vsync pulse
        repeat (6 * 28 + 3) tick();
        push("s_pre_rst_vsync", 32'd1); check(32'(s_vSync));
        Reset_s = 1'b1;
        #1;
        push("s_midrst_h", 32'd13);     check(32'(s_hCount));
        push("s_midrst_v", 32'd9);      check(32'(s_vCount));
        push("s_midrst_vsync", 32'd0);  check(32'(s_vSync));
        push("s_midrst_fcount", 32'd0); check(32'(s_frame_count));
        tick();
        Reset_s = 1'b0;
        push("s_rerel_fs0", 32'd0);     check(32'(s_frame_start));
        tick();
        push("s_rerel_fs1", 32'd1);     check(32'(s_frame_start));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Generates 640x480 @ 60 Hz VGA raster timing from the 100 MHz system clock.
- Drives hSync/vSync to the connector.
- Drives bright, hCount and vCount to the game/render logic, which paints pixels from those counts.
- Provides pixel-enable, line-end and frame-start strobes so game state can advance once per frame without tearing.

Parameters:
- CLK_DIV, 4, system clocks per pixel (100 MHz -> 25 MHz pixel rate); must be >= 2.
- H_VISIBLE, 640, visible pixels per line.
- H_FRONT, 16, horizontal front porch in pixels.
- H_SYNC, 96, horizontal sync width in pixels.
- H_BACK, 48, horizontal back porch in pixels.
- V_VISIBLE, 480, visible lines per frame.
- V_FRONT, 10, vertical front porch in lines.
- V_SYNC, 2, vertical sync width in lines.
- V_BACK, 33, vertical back porch in lines.
- SYNC_POL, 0, active level of hSync/vSync (0 = active-low).

Ports:
- Clk  in  1  system clock, 100 MHz.
- Reset  in  1  asynchronous, active-high reset.
- En  in  1  run enable; low freezes all timing state.
- hCount  out  10  current pixel column, 0..H_TOTAL-1.
- vCount  out  10  current line, 0..V_TOTAL-1.
- bright  out  1  high when (hCount,vCount) is in the visible region.
- hSync  out  1  horizontal sync, level per SYNC_POL.
- vSync  out  1  vertical sync, level per SYNC_POL.
- pix_en  out  1  one-Clk strobe at each pixel advance.
- line_end  out  1  one-Clk strobe coincident with the pix_en that wraps hCount.
- frame_start  out  1  one-Clk strobe coincident with the pix_en that wraps both hCount and vCount to (0,0).
- frame_count  out  16  number of frame starts since reset; wraps 0xFFFF->0.

Behaviour:
- Reset (Clk and Reset already decided): reset Reset, asynchronous, active-high; clock Clk.
- Derived totals: H_TOTAL = sum of the four H parameters = 800; V_TOTAL = sum of the four V parameters = 525.
- Reset values:
  - div counter = 0.
  - hCount = H_TOTAL-1 (799); vCount = V_TOTAL-1 (524).
  - frame_count = 0.
  - bright = 0; hSync = vSync = inactive (~SYNC_POL).
  - pix_en = line_end = frame_start = 0.
- Divider: div counts 0..CLK_DIV-1 while En=1 and wraps to 0. pix_en = En && (div == CLK_DIV-1).
- Raster counters, on each pix_en:
  - If hCount == H_TOTAL-1: hCount <= 0, and vCount advances; vCount wraps from V_TOTAL-1 to 0.
  - Otherwise: hCount <= hCount+1, vCount holds.
- Strobes (combinational from registered state, aligned to the pix_en cycle):
  - line_end = pix_en && hCount == H_TOTAL-1.
  - frame_start = line_end && vCount == V_TOTAL-1.
  - frame_count increments on the Clk edge where frame_start is high.
- First frame after reset: the first pix_en (4th Clk after reset release with En=1) raises frame_start and moves the counters to (0,0). frame_count becomes 1.
- Decodes (combinational from hCount/vCount, zero latency relative to the counts):
  - bright = (hCount < H_VISIBLE) && (vCount < V_VISIBLE).
  - hSync = SYNC_POL when hCount is in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC-1] (656..751); ~SYNC_POL otherwise.
  - vSync = SYNC_POL when vCount is in [V_VISIBLE+V_FRONT, V_VISIBLE+V_FRONT+V_SYNC-1] (490..491); ~SYNC_POL otherwise.
  - hSync and vSync are registered copies of these decodes, so the connector pins are glitch-free. They lag the counts by one Clk, which is well inside one pixel period.
- En low: div, hCount, vCount and frame_count hold; pix_en, line_end and frame_start are 0; decodes continue to reflect the held counts. Re-enabling resumes from the held div value with no skipped or duplicated pixel.
- Reset mid-line or mid-frame: all state returns to the reset values immediately (asynchronous). No partial strobe is emitted after Reset falls until the next genuine wrap.
- Each pixel lasts exactly CLK_DIV Clk cycles. One frame is H_TOTAL*V_TOTAL*CLK_DIV = 1,680,000 Clk with En held high.

Decomposition:
- Shared package vga_pkg:
  - Default timing constants (H_VISIBLE..V_BACK, H_TOTAL, V_TOTAL).
  - 12-bit colour constants BLACK, WHITE, RED, GREEN, so render blocks and this block share one source of truth.
- One sub-module, clk_en_div: parameterised CLK_DIV strobe generator with En, Clk and Reset, producing pix_en.
- Raster counters, decodes and frame counter stay in vga_timing_gen.

Test Plan:
- Reset check: assert Reset mid-frame (hCount=300, vCount=200) -> same Clk: hCount=799, vCount=524, bright=0, hSync=vSync=1, frame_count=0.
- First frame: release Reset with En=1 -> frame_start high exactly on the 4th Clk; next cycle hCount=0, vCount=0, bright=1, frame_count=1.
- Horizontal timing: run one line -> bright high for 640 pixels (2560 Clk); hSync low from hCount 656 through 751 (96 pixels); line_end once per 800 pixels.
- Vertical timing: run one frame -> vSync low only during vCount 490..491; bright never high for vCount>=480; frame_start spacing = 1,680,000 Clk.
- Enable freeze: drop En for 37 Clk at hCount=639 -> counts and frame_count unchanged, no strobes; after En returns, hCount reaches 640 after exactly the remaining divider cycles, and bright falls.
- Counter wrap: force 65,536 frame_start events (or preload frame_count to 0xFFFF in sim) -> frame_count wraps to 0.
